// File: rtl/idx_dec_track.sv
// Registered index decoder and occupancy tracker: set/clear indices update a
// persistent bit vector with count, full/empty flags, one-hot decode and error pulses.
module idx_dec_track #(
  parameter int OUT = 32,
  parameter bit ACT = 1'b1,
  localparam int IDX = $clog2(OUT),
  localparam int CNT = $clog2(OUT + 1)
) (
  input  logic           clk,
  input  logic           reset_,
  input  logic           set_valid,
  input  logic [IDX-1:0] set_idx,
  input  logic           clr_valid,
  input  logic [IDX-1:0] clr_idx,
  input  logic           flush,
  output logic [OUT-1:0] vec,
  output logic           dec_valid,
  output logic [OUT-1:0] dec_oh,
  output logic [CNT-1:0] count,
  output logic           empty,
  output logic           full,
  output logic           dup_err,
  output logic           clr_err,
  output logic           rng_err
);

  localparam logic [31:0]    OUT_U = 32'(OUT);
  localparam logic [OUT-1:0] ONE   = {{(OUT-1){1'b0}}, 1'b1};

  // State is kept active-high internally; ACT only affects the output view.
  logic [OUT-1:0] vec_reg, vec_next;
  logic [OUT-1:0] dec_reg, dec_next;
  logic [CNT-1:0] count_reg, count_next;
  logic           dec_valid_reg, dec_valid_next;
  logic           empty_reg, empty_next;
  logic           full_reg, full_next;
  logic           dup_err_reg, dup_err_next;
  logic           clr_err_reg, clr_err_next;
  logic           rng_err_reg, rng_err_next;

  logic           set_in, clr_in;
  logic           set_ok, clr_ok;
  logic [OUT-1:0] set_oh, clr_oh, after_clr;

  always_comb begin
    set_in = set_valid && (32'(set_idx) < OUT_U);
    clr_in = clr_valid && (32'(clr_idx) < OUT_U);
    rng_err_next = (set_valid && !set_in) || (clr_valid && !clr_in);

    // Clear is applied before set so a same-index pair leaves the bit set.
    clr_oh       = (clr_in && !flush) ? (ONE << clr_idx) : '0;
    clr_ok       = |(vec_reg & clr_oh);
    clr_err_next = (|clr_oh) && !clr_ok;
    after_clr    = vec_reg & ~clr_oh;

    set_oh       = (set_in && !flush) ? (ONE << set_idx) : '0;
    set_ok       = (|set_oh) && !(|(after_clr & set_oh));
    dup_err_next = (|set_oh) && !set_ok;

    dec_valid_next = set_ok;
    dec_next       = set_ok ? set_oh : dec_reg;

    if (flush) begin
      vec_next   = '0;
      count_next = '0;
    end else begin
      vec_next   = after_clr | set_oh;
      count_next = count_reg - CNT'(clr_ok) + CNT'(set_ok);
    end

    empty_next = (count_next == '0);
    full_next  = (count_next == CNT'(OUT));
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      vec_reg       <= '0;
      dec_reg       <= '0;
      count_reg     <= '0;
      dec_valid_reg <= 1'b0;
      empty_reg     <= 1'b1;
      full_reg      <= 1'b0;
      dup_err_reg   <= 1'b0;
      clr_err_reg   <= 1'b0;
      rng_err_reg   <= 1'b0;
    end else begin
      vec_reg       <= vec_next;
      dec_reg       <= dec_next;
      count_reg     <= count_next;
      dec_valid_reg <= dec_valid_next;
      empty_reg     <= empty_next;
      full_reg      <= full_next;
      dup_err_reg   <= dup_err_next;
      clr_err_reg   <= clr_err_next;
      rng_err_reg   <= rng_err_next;
    end
  end

  for (genvar gi = 0; gi < OUT; gi++) begin : g_pol
    assign vec[gi]    = vec_reg[gi] ~^ ACT;
    assign dec_oh[gi] = dec_reg[gi] ~^ ACT;
  end

  assign dec_valid = dec_valid_reg;
  assign count     = count_reg;
  assign empty     = empty_reg;
  assign full      = full_reg;
  assign dup_err   = dup_err_reg;
  assign clr_err   = clr_err_reg;
  assign rng_err   = rng_err_reg;

endmodule

// File: tb/tb_idx_dec_track.sv
// Scoreboard bench: two instances (32 entries active-high, 20 entries active-low)
// share stimulus and are checked against a per-entry reference model.
module tb_idx_dec_track;

  logic       clk = 1'b0;
  logic       reset_;
  logic       set_valid, clr_valid, flush;
  logic [4:0] set_idx, clr_idx;

  logic [31:0] vec0, dec0;
  logic [5:0]  count0;
  logic        dv0, emp0, ful0, dup0, cer0, rng0;
  logic [19:0] vec1, dec1;
  logic [4:0]  count1;
  logic        dv1, emp1, ful1, dup1, cer1, rng1;

  idx_dec_track #(.OUT(32), .ACT(1'b1)) dut0 (
    .clk(clk), .reset_(reset_), .set_valid(set_valid), .set_idx(set_idx),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .flush(flush),
    .vec(vec0), .dec_valid(dv0), .dec_oh(dec0), .count(count0), .empty(emp0),
    .full(ful0), .dup_err(dup0), .clr_err(cer0), .rng_err(rng0)
  );

  idx_dec_track #(.OUT(20), .ACT(1'b0)) dut1 (
    .clk(clk), .reset_(reset_), .set_valid(set_valid), .set_idx(set_idx),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .flush(flush),
    .vec(vec1), .dec_valid(dv1), .dec_oh(dec1), .count(count1), .empty(emp1),
    .full(ful1), .dup_err(dup1), .clr_err(cer1), .rng_err(rng1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tgt;
    logic [31:0] vec;
    logic [31:0] dec;
    logic        dv;
    int          cnt;
    logic        emp, ful, dup, cer, rng;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e_mon;

  bit mv[2][32];   // entry occupied, per instance
  bit mdh[2][32];  // last accepted decode, active-high
  int checks = 0;
  int errors = 0;
  int unsigned edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic exp_t build(int k, logic dv, logic dup, logic cer, logic rng);
    exp_t e;
    int w = (k == 0) ? 32 : 20;
    bit act = (k == 0);
    int n = 0;
    e.tgt = 0;
    e.vec = '0;
    e.dec = '0;
    for (int i = 0; i < w; i++) begin
      e.vec[i] = mv[k][i] ? act : !act;
      e.dec[i] = mdh[k][i] ? act : !act;
      n += int'(mv[k][i]);
    end
    e.cnt = n;
    e.emp = (n == 0);
    e.ful = (n == w);
    e.dv  = dv;
    e.dup = dup;
    e.cer = cer;
    e.rng = rng;
    return e;
  endfunction

  task automatic model(input int k, input bit sv, input int si, input bit cv,
                       input int ci, input bit fl, output exp_t e);
    int w = (k == 0) ? 32 : 20;
    logic dv = 0, dup = 0, cer = 0, rng;
    bit sin = sv && (si < w);
    bit cin = cv && (ci < w);
    rng = (sv && !sin) || (cv && !cin);
    if (fl) begin
      for (int i = 0; i < 32; i++) mv[k][i] = 0;
    end else begin
      if (sin && cin && si == ci) begin
        if (!mv[k][si]) cer = 1;
        mv[k][si] = 1;
        dv = 1;
      end else begin
        if (cin) begin
          if (mv[k][ci]) mv[k][ci] = 0;
          else cer = 1;
        end
        if (sin) begin
          if (mv[k][si]) dup = 1;
          else begin
            mv[k][si] = 1;
            dv = 1;
          end
        end
      end
      if (dv) for (int i = 0; i < 32; i++) mdh[k][i] = (i == si);
    end
    e = build(k, dv, dup, cer, rng);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mv[k][i]  = 0;
        mdh[k][i] = 0;
      end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic cmp(input int k, input exp_t e);
    if (k == 0) begin
      chk("vec0", vec0, e.vec);
      chk("dec_oh0", dec0, e.dec);
      chk("dec_valid0", 32'(dv0), 32'(e.dv));
      chk("count0", 32'(count0), 32'(e.cnt));
      chk("empty0", 32'(emp0), 32'(e.emp));
      chk("full0", 32'(ful0), 32'(e.ful));
      chk("dup_err0", 32'(dup0), 32'(e.dup));
      chk("clr_err0", 32'(cer0), 32'(e.cer));
      chk("rng_err0", 32'(rng0), 32'(e.rng));
      $display("txn edge %0d dut0 vec=%h cnt=%0d dv=%b dup=%b clr=%b rng=%b",
               edge_cnt, vec0, count0, dv0, dup0, cer0, rng0);
    end else begin
      chk("vec1", {12'b0, vec1}, e.vec);
      chk("dec_oh1", {12'b0, dec1}, e.dec);
      chk("dec_valid1", 32'(dv1), 32'(e.dv));
      chk("count1", 32'(count1), 32'(e.cnt));
      chk("empty1", 32'(emp1), 32'(e.emp));
      chk("full1", 32'(ful1), 32'(e.ful));
      chk("dup_err1", 32'(dup1), 32'(e.dup));
      chk("clr_err1", 32'(cer1), 32'(e.cer));
      chk("rng_err1", 32'(rng1), 32'(e.rng));
      $display("txn edge %0d dut1 vec=%h cnt=%0d dv=%b dup=%b clr=%b rng=%b",
               edge_cnt, vec1, count1, dv1, dup1, cer1, rng1);
    end
  endtask

  // Monitor: pops an expectation once the edge it targets has occurred.
  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].tgt <= edge_cnt) begin
      e_mon = q0.pop_front();
      cmp(0, e_mon);
    end
    while (q1.size() > 0 && q1[0].tgt <= edge_cnt) begin
      e_mon = q1.pop_front();
      cmp(1, e_mon);
    end
  end

  task automatic step(input bit sv, input int si, input bit cv, input int ci, input bit fl);
    exp_t e0, e1;
    set_valid = sv;
    set_idx   = 5'(si);
    clr_valid = cv;
    clr_idx   = 5'(ci);
    flush     = fl;
    model(0, sv, si, cv, ci, fl, e0);
    model(1, sv, si, cv, ci, fl, e1);
    e0.tgt = edge_cnt + 1;
    e1.tgt = edge_cnt + 1;
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk();
    cmp(0, build(0, 0, 0, 0, 0));
    cmp(1, build(1, 0, 0, 0, 0));
  endtask

  task automatic idle();
    set_valid = 0;
    clr_valid = 0;
    flush     = 0;
    set_idx   = '0;
    clr_idx   = '0;
  endtask

  initial begin
    reset_ = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_chk();
    reset_ = 1'b1;

    for (int i = 0; i < 32; i++) step(1, i, 0, 0, 0);       // fill
    for (int i = 31; i >= 0; i--) step(0, 0, 1, i, 0);      // drain

    step(1, 4, 0, 0, 0);                                     // same-index collision
    step(1, 4, 1, 4, 0);
    step(0, 0, 1, 4, 0);
    step(1, 4, 1, 4, 0);
    step(0, 0, 1, 4, 0);

    step(1, 3, 0, 0, 0);                                     // duplicate / bad clear / range
    step(1, 3, 0, 0, 0);
    step(0, 0, 1, 7, 0);
    step(1, 25, 0, 0, 0);
    step(1, 9, 1, 3, 0);
    step(0, 0, 1, 22, 0);

    for (int i = 0; i < 32; i++) step(1, i, 0, 0, 0);       // flush beats set
    step(1, 2, 0, 0, 1);
    step(1, 2, 1, 5, 0);

    repeat (400) begin
      step($urandom_range(0, 9) < 6, int'($urandom_range(0, 31)),
           $urandom_range(0, 9) < 4, int'($urandom_range(0, 31)),
           $urandom_range(0, 31) == 0);
    end

    step(0, 0, 0, 0, 1);                                     // mid-run reset with vec=0xFF
    for (int i = 0; i < 8; i++) step(1, i, 0, 0, 0);
    idle();
    @(negedge clk);
    #1;
    reset_ = 1'b0;
    #1;
    model_reset();
    rst_chk();
    @(posedge clk);
    #1;
    reset_ = 1'b1;

    repeat (100) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
           $urandom_range(0, 31) == 0);
    end
    idle();

    repeat (2) @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idx_dec_track.md
# idx_dec_track

Registered index decoder and occupancy tracker: the inverse of the priority-encode path. It turns binary set/clear indices into a one-hot decode and a persistent bit vector with occupancy count and full/empty flags. It sits beside a priority encoder in allocate/release loops such as free lists, tag pools and busy tables. The encoder picks an index from the vector, and this block writes indices back into it.

## Interface
- OUT, 32, number of entries (vector width); any value ≥ 2
- ACT, `High, polarity of `vec` and `dec_oh` bits: `High means 1 = set; `Low means 0 = set
- IDX, $clog2(OUT), index width (constant, not overridden)
- CNT, $clog2(OUT+1), count width (constant, not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset_  in  1  asynchronous, active-low reset
- set_valid  in  1  set request, active-high
- set_idx  in  IDX  index to set
- clr_valid  in  1  clear request, active-high
- clr_idx  in  IDX  index to clear
- flush  in  1  clear all entries, active-high
- vec  out  OUT  tracked bit vector, polarity per ACT
- dec_valid  out  1  one-cycle pulse: `dec_oh` holds the decode of an accepted set
- dec_oh  out  OUT  registered one-hot decode of the last accepted `set_idx`, polarity per ACT
- count  out  CNT  number of set entries
- empty  out  1  count == 0
- full  out  1  count == OUT
- dup_err  out  1  one-cycle pulse: set of an already-set entry
- clr_err  out  1  one-cycle pulse: clear of an already-clear entry
- rng_err  out  1  one-cycle pulse: any valid index ≥ OUT

## Operation

**Reset** (asynchronous, `reset_` low):
- `vec` = all DISABLE.
- `dec_oh` = all DISABLE, `dec_valid` = 0.
- `count` = 0, `empty` = 1, `full` = 0.
- All error pulses = 0.

**Per cycle, evaluated on the current registered `vec`:**
- **flush = 1:** next `vec` = all DISABLE and `count` = 0. Set and clear requests are ignored: no `dec_valid`, no dup/clr errors. `rng_err` is still reported.
- **Accepted set:** `set_valid` = 1, `set_idx` < OUT, entry currently clear, and no flush.
  - Bit becomes ENABLE.
  - `dec_oh` = one-hot(`set_idx`) in ACT polarity.
  - `dec_valid` = 1.
- **Accepted clear:** `clr_valid` = 1, `clr_idx` < OUT, entry currently set, and no flush.
  - Bit becomes DISABLE.
- **Set and clear of the same index in one cycle:** the clear is applied first, then the set. The final bit is set.
  - If the entry was set: count unchanged, `dec_valid` = 1, no errors.
  - If the entry was clear: the set is accepted and `clr_err` = 1.
- **Set and clear of different indices in one cycle:** both are applied independently. Count changes by +1, −1, or 0 accordingly.
- **Set of an already-set entry:** no change; `dup_err` = 1.
- **Clear of an already-clear entry:** no change; `clr_err` = 1.
- **Index ≥ OUT on either valid port:** that request is ignored; `rng_err` = 1. This case only arises when OUT is not a power of 2.
- **`dec_oh`** holds its value when there is no accepted set. It is cleared only by reset.
- **`count`** is a register updated with `vec`. `empty` and `full` are registered, derived from the next count.
- **Invariant:** popcount(`vec` in ACT-high terms) == `count` at all times.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Latency is 1 cycle: a request at edge N is visible on `vec`, `count`, flags, `dec_*` and errors after edge N.
- There is no backpressure; a request can be accepted every cycle.
- Error pulses and `dec_valid` last exactly one cycle per offending or accepting request cycle.
- A reset assertion mid-stream clears state immediately (asynchronously). The first request is accepted on the first rising edge after `reset_` deasserts.

## Test plan
- **Reset:** assert `reset_`=0 mid-run with `vec`=0x0000_00FF → immediately `vec`=0, `count`=0, `empty`=1, `dec_valid`=0.
- **Fill and drain:** set idx 0..31 on consecutive cycles (OUT=32, ACT=`High) → `count` increments by 1 per cycle; `dec_oh`=1<<idx each cycle; `full`=1 after the 32nd edge. Then clear 31..0 → `empty`=1 after 32 edges.
- **Same-index collision:** with `vec`=0x10, set_idx=4 and clr_idx=4 together → `vec`=0x10, `count`=1, `dec_valid`=1, no errors. Repeat with `vec`=0 → `vec`=0x10, `clr_err`=1.
- **Errors:** set idx 3 twice → second cycle gives `dup_err`=1 and `count` stays 1. Clear idx 7 while clear → `clr_err`=1. With OUT=20, set_idx=25 → `rng_err`=1 and `vec` unchanged.
- **Flush priority:** `vec`=0xFFFF_FFFF, flush=1 with set_idx=2 → `vec`=0, `count`=0, `dec_valid`=0.
- **ACT=`Low:** after reset `vec`=0xFFFF_FFFF; set idx 0 → `vec`=0xFFFF_FFFE, `dec_oh`=0xFFFF_FFFE, `count`=1.
